data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 138 +++++++++++++
 tb/tb_data_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Purpose : byte-addressable data memory for the MEM stage, DEPTH x 32-bit words, little-endian lanes.
// Latency : loads are combinational (0 cycles); stores and error capture commit on the rising Clk edge.
// Backpressure: none; one access per cycle is always accepted.
//
// Ports:
//   Clk, Rst            - rising-edge clock, synchronous active-high reset (clears array and error state)
//   Address             - byte address; bits above the array span are ignored (wraps modulo DEPTH*4)
//   WriteData           - store data, right-justified for byte/half stores
//   MemWrite, MemRead   - store / load enables
//   MemSize             - 00 word, 01 half, 10 byte, 11 treated as word
//   MemSigned           - sign-extend byte/half loads when 1
//   ReadData            - load result, zero when not reading, in reset, or misaligned
//   MisalignErr/ErrAddr - sticky flag and address of the first misaligned access since reset
module data_memory #(
  parameter int DEPTH = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] ReadData,
  output logic        MisalignErr,
  output logic [31:0] ErrAddr
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
    $error("data_memory: DEPTH must be a power of two >= 2");
  end

  // Word storage has no reset of its own. A per-word valid bit is cleared
  // on reset instead, and an invalid word reads as zero, so a single-edge
  // reset behaves exactly like clearing every word.
  logic [31:0]      memArray [DEPTH];
  logic [DEPTH-1:0] wordValid;

  logic [AW-1:0] wordIdx;
  logic [31:0]   curWord;
  logic          misaligned;
  logic          accessEn;
  logic          storeEn;
  logic [3:0]    byteEn;
  logic [31:0]   laneData;
  logic [31:0]   laneMask;
  logic [31:0]   mergedWord;
  logic [15:0]   halfSel;
  logic [7:0]    byteSel;

  assign wordIdx = Address[AW+1:2];
  assign curWord = wordValid[wordIdx] ? memArray[wordIdx] : 32'h0;

  // Byte accesses are always aligned; halves need bit 0 clear; word and the
  // reserved size code need both low bits clear.
  always_comb begin
    misaligned = 1'b0;
    case (MemSize)
      2'b01:   misaligned = Address[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (Address[1:0] != 2'b00);
    endcase
  end

  assign accessEn = MemRead | MemWrite;
  assign storeEn  = MemWrite & ~Rst & ~misaligned;

  // Store data is replicated across all lanes so the byte enables alone
  // decide which lanes land in the word.
  always_comb begin
    byteEn   = 4'b1111;
    laneData = WriteData;
    case (MemSize)
      2'b01: begin
        byteEn   = Address[1] ? 4'b1100 : 4'b0011;
        laneData = {2{WriteData[15:0]}};
      end
      2'b10: begin
        byteEn   = 4'b0001 << Address[1:0];
        laneData = {4{WriteData[7:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = WriteData;
      end
    endcase
  end

  assign laneMask   = {{8{byteEn[3]}}, {8{byteEn[2]}}, {8{byteEn[1]}}, {8{byteEn[0]}}};
  assign mergedWord = (curWord & ~laneMask) | (laneData & laneMask);

  // Always write the full merged word; a partial store into a word that is
  // still invalid after reset therefore fills the untouched lanes with zero.
  always_ff @(posedge Clk) begin
    if (storeEn) begin
      memArray[wordIdx] <= mergedWord;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wordValid <= '0;
    end else if (storeEn) begin
      wordValid[wordIdx] <= 1'b1;
    end
  end

  // Only the first misaligned access after reset is recorded.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      MisalignErr <= 1'b0;
      ErrAddr     <= 32'h0;
    end else if (accessEn && misaligned && !MisalignErr) begin
      MisalignErr <= 1'b1;
      ErrAddr     <= Address;
    end
  end

  assign halfSel = Address[1] ? curWord[31:16] : curWord[15:0];
  assign byteSel = curWord[{Address[1:0], 3'b000} +: 8];

  // Load path reads the pre-edge contents, so a simultaneous read and write
  // returns the old word during the cycle.
  always_comb begin
    ReadData = 32'h0;
    if (MemRead && !Rst && !misaligned) begin
      case (MemSize)
        2'b01:   ReadData = {{16{MemSigned & halfSel[15]}}, halfSel};
        2'b10:   ReadData = {{24{MemSigned & byteSel[7]}}, byteSel};
        default: ReadData = curWord;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] ReadData;
  logic        MisalignErr;
  logic [31:0] ErrAddr;

  data_memory #(.DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .MemSize     (MemSize),
    .MemSigned   (MemSigned),
    .ReadData    (ReadData),
    .MisalignErr (MisalignErr),
    .ErrAddr     (ErrAddr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    Rst       = rst;
    MemRead   = rd;
    MemWrite  = wr;
    MemSize   = size;
    MemSigned = sgn;
    Address   = addr;
    WriteData = wdata;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expErr;
    logic [31:0] expEa;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input string name, input logic rd, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRd, input logic expErr, input logic [31:0] expEa);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn;
    v.addr = addr; v.wdata = wdata; v.expRd = expRd; v.expErr = expErr; v.expEa = expEa;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  mMem [BYTES];
  logic        mErr;
  logic [31:0] mEa;

  function automatic int nBytes(input logic [1:0] size);
    if (size == 2'b01) return 2;
    if (size == 2'b10) return 1;
    return 4;
  endfunction

  function automatic bit isMis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % 32'(nBytes(size))) != 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    int n = nBytes(size);
    int base = int'(addr % 32'(BYTES));
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mMem[base + k]) << (8 * k));
    if (sgn && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < BYTES; i++) mMem[i] = 8'h0;
    mErr = 1'b0;
    mEa  = 32'h0;
  endfunction

  function automatic void modelEdge(input logic rst, input logic rd, input logic wr, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata);
    int n = nBytes(size);
    int base = int'(addr % 32'(BYTES));
    bit mis = isMis(size, addr);
    if (rst) begin
      modelClear();
    end else begin
      if (wr && !mis)
        for (int k = 0; k < n; k++) mMem[base + k] = wdata[8 * k +: 8];
      if ((rd || wr) && mis && !mErr) begin
        mErr = 1'b1;
        mEa  = addr;
      end
    end
  endfunction

  initial begin
    drive(1, 1, 0, 2'b00, 0, 32'h0, 32'h0);

    // Reset state
    tick;
    tick;
    check("reset.rd", ReadData, 32'h0);
    check("reset.err", {31'b0, MisalignErr}, 32'h0);
    check("reset.ea", ErrAddr, 32'h0);

    //    name        rd wr size sgn addr          wdata          expRd          err ea
    addv("sw10",      0, 1, 2'b00, 0, 32'h10,   32'h8000_00FF, 32'h0,         0, 32'h0);
    addv("lw10",      1, 0, 2'b00, 0, 32'h10,   32'h0,         32'h8000_00FF, 0, 32'h0);
    addv("lb10s",     1, 0, 2'b10, 1, 32'h10,   32'h0,         32'hFFFF_FFFF, 0, 32'h0);
    addv("lbu13",     1, 0, 2'b10, 0, 32'h13,   32'h0,         32'h0000_0080, 0, 32'h0);
    addv("sw20",      0, 1, 2'b00, 0, 32'h20,   32'h1122_3344, 32'h0,         0, 32'h0);
    addv("sh22",      0, 1, 2'b01, 0, 32'h22,   32'h0000_ABCD, 32'h0,         0, 32'h0);
    addv("lw20",      1, 0, 2'b00, 0, 32'h20,   32'h0,         32'hABCD_3344, 0, 32'h0);
    addv("lh22s",     1, 0, 2'b01, 1, 32'h22,   32'h0,         32'hFFFF_ABCD, 0, 32'h0);
    addv("lhu20",     1, 0, 2'b01, 0, 32'h20,   32'h0,         32'h0000_3344, 0, 32'h0);
    addv("lw20sz3",   1, 0, 2'b11, 0, 32'h20,   32'h0,         32'hABCD_3344, 0, 32'h0);
    addv("sw1000",    0, 1, 2'b00, 0, 32'h1000, 32'h5A5A_5A5A, 32'h0,         0, 32'h0);
    addv("lw0wrap",   1, 0, 2'b00, 0, 32'h0,    32'h0,         32'h5A5A_5A5A, 0, 32'h0);
    addv("sw40",      0, 1, 2'b00, 0, 32'h40,   32'h1,         32'h0,         0, 32'h0);
    addv("rdwr40",    1, 1, 2'b00, 0, 32'h40,   32'h2,         32'h1,         0, 32'h0);
    addv("lw40",      1, 0, 2'b00, 0, 32'h40,   32'h0,         32'h2,         0, 32'h0);
    addv("sb41",      0, 1, 2'b10, 0, 32'h41,   32'hABCD_EF77, 32'h0,         0, 32'h0);
    addv("lw40b",     1, 0, 2'b00, 0, 32'h40,   32'h0,         32'h0000_7702, 0, 32'h0);
    addv("sb50",      0, 1, 2'b10, 0, 32'h50,   32'h11,        32'h0,         0, 32'h0);
    addv("sb51",      0, 1, 2'b10, 0, 32'h51,   32'h22,        32'h0,         0, 32'h0);
    addv("sh52",      0, 1, 2'b01, 0, 32'h52,   32'h3344,      32'h0,         0, 32'h0);
    addv("lw50",      1, 0, 2'b00, 0, 32'h50,   32'h0,         32'h3344_2211, 0, 32'h0);
    addv("idle31",    0, 0, 2'b00, 0, 32'h31,   32'hDEAD_BEEF, 32'h0,         0, 32'h0);
    addv("nord10",    0, 0, 2'b00, 0, 32'h10,   32'h0,         32'h0,         0, 32'h0);
    addv("swmis31",   0, 1, 2'b00, 0, 32'h31,   32'hDEAD_BEEF, 32'h0,         1, 32'h31);
    addv("lw30",      1, 0, 2'b00, 0, 32'h30,   32'h0,         32'h0,         1, 32'h31);
    addv("lhmis45",   1, 0, 2'b01, 1, 32'h45,   32'h0,         32'h0,         1, 32'h31);
    addv("lwmis12",   1, 0, 2'b00, 0, 32'h12,   32'h0,         32'h0,         1, 32'h31);
    addv("lw10post",  1, 0, 2'b00, 0, 32'h10,   32'h0,         32'h8000_00FF, 1, 32'h31);

    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;
    foreach (vecs[i]) begin
      drive(0, vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
      #2;
      check($sformatf("%s.rd", vecs[i].name), ReadData, vecs[i].expRd);
      tick;
      check($sformatf("%s.err", vecs[i].name), {31'b0, MisalignErr}, {31'b0, vecs[i].expErr});
      check($sformatf("%s.ea", vecs[i].name), ErrAddr, vecs[i].expEa);
    end

    // Reset priority over a coincident store, and discard of prior stores
    drive(0, 0, 1, 2'b00, 0, 32'h8, 32'h7);
    tick;
    drive(0, 1, 0, 2'b00, 0, 32'h8, 32'h0);
    #2;
    check("rst.pre_lw8", ReadData, 32'h7);
    tick;
    drive(1, 1, 1, 2'b00, 0, 32'h8, 32'h9);
    #2;
    check("rst.rd_during", ReadData, 32'h0);
    tick;
    check("rst.err", {31'b0, MisalignErr}, 32'h0);
    check("rst.ea", ErrAddr, 32'h0);
    drive(0, 1, 0, 2'b00, 0, 32'h8, 32'h0);
    #2;
    check("rst.lw8", ReadData, 32'h0);
    drive(0, 1, 0, 2'b00, 0, 32'h10, 32'h0);
    #2;
    check("rst.lw10", ReadData, 32'h0);
    drive(0, 1, 0, 2'b00, 0, 32'h0, 32'h0);
    #2;
    check("rst.lw0", ReadData, 32'h0);
    tick;
    drive(1, 0, 1, 2'b00, 0, 32'h9, 32'h1234_5678);
    tick;
    check("rstmis.err", {31'b0, MisalignErr}, 32'h0);
    check("rstmis.ea", ErrAddr, 32'h0);

    // Randomised run against the byte-array model
    drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    tick;
    modelClear();
    for (int it = 0; it < 3000; it++) begin
      logic        rst, rd, wr, sgn;
      logic [1:0]  size;
      logic [31:0] addr, wdata, expRd;
      rst   = ($urandom_range(0, 99) == 0);
      rd    = 1'($urandom_range(0, 1));
      wr    = ($urandom_range(0, 2) != 0);
      size  = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      addr  = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_F000) : 32'h0) | 32'($urandom_range(0, 255));
      wdata = $urandom;
      expRd = (rst || !rd || isMis(size, addr)) ? 32'h0 : modelRead(size, sgn, addr);
      drive(rst, rd, wr, size, sgn, addr, wdata);
      #2;
      check($sformatf("rnd%0d.rd", it), ReadData, expRd);
      modelEdge(rst, rd, wr, size, addr, wdata);
      tick;
      check($sformatf("rnd%0d.err", it), {31'b0, MisalignErr}, {31'b0, mErr});
      check($sformatf("rnd%0d.ea", it), ErrAddr, mEa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
